// File: rtl/des_stream_pkg.sv
// Shared types and constants for the DES byte-stream controller.
package des_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY,
      ST_TEXT,
      ST_ISSUE,
      ST_WAIT,
      ST_DRAIN
   } state_e;

   localparam int unsigned CMD_DIR_BIT     = 0;
   localparam int unsigned CMD_LOADKEY_BIT = 1;
   localparam int unsigned BLOCK_BYTES     = 8;
   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned BLOCK_W         = BLOCK_BYTES * BYTE_W;
   localparam int unsigned BCNT_W          = 3;

endpackage

// File: rtl/des_shift64.sv
// 64-bit byte shift register: parallel load, shift left by one byte, exposes top OUT_W bits.
module des_shift64
   import des_stream_pkg::*;
#(
   parameter int unsigned OUT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [63:0]       load_data_i,
   input  logic              shift_i,
   input  logic [7:0]        shift_in_i,
   output logic [OUT_W-1:0]  data_o
);

   logic [BLOCK_W-1:0] sr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= load_data_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[BLOCK_W-BYTE_W-1:0], shift_in_i};
      end
   end

   assign data_o = sr_q[BLOCK_W-1 -: OUT_W];

endmodule

// File: rtl/des_stream_ctrl.sv
// Byte-stream host front end for des_top: gathers command/key/text bytes,
// fires one DES operation and streams the 8-byte result back out.
module des_stream_ctrl
   import des_stream_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] des_key,
   output logic [63:0] des_text,
   output logic        des_encrypt_decrypt,
   output logic        des_valid_in,
   input  logic [63:0] des_cipher_text,
   input  logic        des_valid_out,
   output logic        busy,
   output logic        err_timeout
);

   state_e             state_q, state_d;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] key_q, key_d;
   logic               dir_q, dir_d;
   logic               err_q, err_d;
   logic               s_ready_q, m_valid_q, busy_q, vld_in_q;
   logic               ing_shift, eg_load, eg_shift;
   logic               s_xfer, m_xfer, last_byte;
   logic [BLOCK_W-1:0] ing_data;
   logic [BYTE_W-1:0]  eg_top;

   assign s_xfer    = s_valid && s_ready_q;
   assign m_xfer    = m_valid_q && m_ready;
   assign last_byte = (bcnt_q == BCNT_W'(BLOCK_BYTES - 1));

   // Ingress staging: key bytes pass through here, then the text block stays as des_text.
   des_shift64 #(.OUT_W(BLOCK_W)) u_ingress (
      .clk         (clk),
      .rst         (rst),
      .load_i      (1'b0),
      .load_data_i ('0),
      .shift_i     (ing_shift),
      .shift_in_i  (s_data),
      .data_o      (ing_data)
   );

   des_shift64 #(.OUT_W(BYTE_W)) u_egress (
      .clk         (clk),
      .rst         (rst),
      .load_i      (eg_load),
      .load_data_i (des_cipher_text),
      .shift_i     (eg_shift),
      .shift_in_i  ('0),
      .data_o      (eg_top)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bcnt_q    <= '0;
         cnt_q     <= '0;
         key_q     <= '0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         vld_in_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         s_ready_q <= (state_d == ST_IDLE) || (state_d == ST_KEY) || (state_d == ST_TEXT);
         m_valid_q <= (state_d == ST_DRAIN);
         busy_q    <= (state_d != ST_IDLE);
         vld_in_q  <= (state_d == ST_ISSUE);
      end
   end

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      dir_d     = dir_q;
      err_d     = err_q;
      ing_shift = 1'b0;
      eg_load   = 1'b0;
      eg_shift  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_xfer) begin
               dir_d   = s_data[CMD_DIR_BIT];
               err_d   = 1'b0;
               bcnt_d  = '0;
               state_d = s_data[CMD_LOADKEY_BIT] ? ST_KEY : ST_TEXT;
            end
         end
         ST_KEY: begin
            if (s_xfer) begin
               ing_shift = 1'b1;
               bcnt_d    = bcnt_q + BCNT_W'(1);
               if (last_byte) begin
                  key_d   = {ing_data[BLOCK_W-BYTE_W-1:0], s_data};
                  state_d = ST_TEXT;
               end
            end
         end
         ST_TEXT: begin
            if (s_xfer) begin
               ing_shift = 1'b1;
               bcnt_d    = bcnt_q + BCNT_W'(1);
               if (last_byte) state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         // A result arriving on the timeout boundary still wins.
         ST_WAIT: begin
            if (des_valid_out) begin
               eg_load = 1'b1;
               bcnt_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (m_xfer) begin
               eg_shift = 1'b1;
               bcnt_d   = bcnt_q + BCNT_W'(1);
               if (last_byte) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign s_ready             = s_ready_q;
   assign m_data              = eg_top;
   assign m_valid             = m_valid_q;
   assign des_key             = key_q;
   assign des_text            = ing_data;
   assign des_encrypt_decrypt = dir_q;
   assign des_valid_in        = vld_in_q;
   assign busy                = busy_q;
   assign err_timeout         = err_q;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Directed bench for des_stream_ctrl with a fixed-latency des_top stub.
module tb_des_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [63:0] des_key, des_text;
   logic        des_encrypt_decrypt, des_valid_in;
   logic [63:0] des_cipher_text = '0;
   logic        des_valid_out = 1'b0;
   logic        busy, err_timeout;

   int          n_checks = 0;
   int          n_fail = 0;
   int          vi_cnt = 0;
   int          stub_lat = 0;
   logic [63:0] stub_ct = '0;
   bit          armed = 0;
   int          k_stub = 0;

   des_stream_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .des_key(des_key), .des_text(des_text),
      .des_encrypt_decrypt(des_encrypt_decrypt), .des_valid_in(des_valid_in),
      .des_cipher_text(des_cipher_text), .des_valid_out(des_valid_out),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // des_top stub: answers stub_lat negedges after seeing valid_in (0 = never).
   always @(negedge clk) begin
      des_valid_out = 1'b0;
      if (rst) begin
         armed = 0;
      end else if (des_valid_in) begin
         armed  = 1;
         k_stub = 0;
         vi_cnt = vi_cnt + 1;
      end else if (armed) begin
         k_stub = k_stub + 1;
         if (stub_lat != 0 && k_stub == stub_lat) begin
            des_valid_out   = 1'b1;
            des_cipher_text = stub_ct;
            armed           = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Entered and left on a negedge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("s_ready_wait", 64'(s_ready), 64'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] v);
      logic [63:0] sh;
      sh = v;
      for (int i = 0; i < 8; i++) begin
         send_byte(sh[63:56]);
         sh = sh << 8;
      end
   endtask

   // Sends one command; returns one negedge after the valid_in pulse.
   task automatic issue_op(input logic [7:0] cmd, input logic [63:0] key,
                           input logic [63:0] text, input logic [63:0] exp_key);
      send_byte(cmd);
      if (cmd[1]) send_block(key);
      send_block(text);
      check("vi_pulse", 64'(des_valid_in), 64'd1);
      check("vi_key", des_key, exp_key);
      check("vi_text", des_text, text);
      check("vi_dir", 64'(des_encrypt_decrypt), 64'(cmd[0]));
      check("vi_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("vi_single", 64'(des_valid_in), 64'd0);
   endtask

   task automatic recv_block(input logic [63:0] exp, input bit bp, input int max_bytes);
      int          nb = 0;
      int          cyc = 0;
      int          since = 0;
      bit          stalled = 0;
      logic [7:0]  held = '0;
      logic [63:0] sh;
      sh = exp;
      while (nb < max_bytes && cyc < 400) begin
         if (m_valid) begin
            check("rx_busy", 64'(busy), 64'd1);
            if (stalled) check("rx_hold", 64'(m_data), 64'(held));
            m_ready = bp ? (since >= 5 && ((since - 5) % 2) == 0) : 1'b1;
            if (m_ready) begin
               check($sformatf("rx_byte%0d", nb), 64'(m_data), 64'(sh[63:56]));
               sh      = sh << 8;
               nb++;
               stalled = 0;
            end else begin
               held    = m_data;
               stalled = 1;
            end
            since++;
         end else begin
            m_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      if (nb < max_bytes) check("rx_count", 64'(nb), 64'(max_bytes));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_key", des_key, 64'd0);
      check("rst_text", des_text, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_timeout), 64'd0);
      check("rst_vi", 64'(des_valid_in), 64'd0);
      check("rst_dir", 64'(des_encrypt_decrypt), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", 64'(s_ready), 64'd1);

      // 1: encrypt with key load
      stub_lat = 16;
      stub_ct  = 64'h85E813540F0AB405;
      issue_op(8'h02, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
      check("t1_no_mvalid_early", 64'(m_valid), 64'd0);
      recv_block(64'h85E813540F0AB405, 0, 8);
      check("t1_mvalid_drop", 64'(m_valid), 64'd0);
      check("t1_idle", 64'(busy), 64'd0);

      // 2: decrypt reusing key
      stub_ct = 64'h0123456789ABCDEF;
      issue_op(8'h01, 64'h0, 64'h85E813540F0AB405, 64'h133457799BBCDFF1);
      recv_block(64'h0123456789ABCDEF, 0, 8);
      check("t2_idle", 64'(busy), 64'd0);

      // 3: egress backpressure
      stub_ct = 64'hA1B2C3D4E5F60718;
      issue_op(8'h00, 64'h0, 64'h0011223344556677, 64'h133457799BBCDFF1);
      recv_block(64'hA1B2C3D4E5F60718, 1, 8);
      check("t3_mvalid_drop", 64'(m_valid), 64'd0);
      check("t3_idle", 64'(busy), 64'd0);

      // 4: timeout, late result dropped, next command clears flag
      stub_lat = 70;
      stub_ct  = 64'hDEADBEEFCAFEF00D;
      issue_op(8'h00, 64'h0, 64'h1111111111111111, 64'h133457799BBCDFF1);
      for (int k = 2; k <= 65; k++) begin
         @(negedge clk);
         if (k == 64) begin
            check("t4_err_before", 64'(err_timeout), 64'd0);
            check("t4_busy_before", 64'(busy), 64'd1);
         end
      end
      check("t4_err_set", 64'(err_timeout), 64'd1);
      check("t4_idle", 64'(busy), 64'd0);
      check("t4_s_ready", 64'(s_ready), 64'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t4_no_egress", 64'(m_valid), 64'd0);
      end
      check("t4_err_sticky", 64'(err_timeout), 64'd1);
      stub_lat = 16;
      stub_ct  = 64'h0F1E2D3C4B5A6978;
      send_byte(8'h00);
      check("t4_err_clear", 64'(err_timeout), 64'd0);
      send_block(64'h2222222222222222);
      check("t4b_vi", 64'(des_valid_in), 64'd1);
      recv_block(64'h0F1E2D3C4B5A6978, 0, 8);

      // 5: reset mid-drain
      stub_ct = 64'h85E813540F0AB405;
      issue_op(8'h02, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
      recv_block(64'h85E813540F0AB405, 0, 3);
      rst = 1'b1;
      #1;
      check("t5_mvalid", 64'(m_valid), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_key", des_key, 64'd0);
      check("t5_mdata", 64'(m_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stub_ct = 64'h8CA64DE9C1B123A7;
      issue_op(8'h00, 64'h0, 64'h0000000000000000, 64'h0);
      recv_block(64'h8CA64DE9C1B123A7, 0, 8);

      // 6: result coincides with timeout boundary
      stub_lat = 64;
      stub_ct  = 64'h5A5A0102A5A50304;
      issue_op(8'h00, 64'h0, 64'h3333333333333333, 64'h0);
      for (int k = 2; k <= 65; k++) @(negedge clk);
      check("t6_mvalid", 64'(m_valid), 64'd1);
      check("t6_err", 64'(err_timeout), 64'd0);
      check("t6_busy", 64'(busy), 64'd1);
      recv_block(64'h5A5A0102A5A50304, 0, 8);
      check("t6_err_after", 64'(err_timeout), 64'd0);

      check("vi_total", 64'(vi_cnt), 64'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
